// File: rtl/fb_block_reader_pkg.sv
// Shared types and constants for the framebuffer block reader.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fb_pkg;

  localparam int PIXEL_BITS   = 16;
  localparam int BLOCK_BITS   = 4096;
  localparam int PPB          = BLOCK_BITS / PIXEL_BITS;
  localparam int FRAME_PIXELS = 786432;
  localparam int ADDR_BITS    = 27;
  localparam int IDX_BITS     = $clog2(PPB);

  typedef logic [PIXEL_BITS-1:0]           pixel_t;
  typedef logic [PPB-1:0][PIXEL_BITS-1:0]  block_t;
  typedef logic [IDX_BITS-1:0]             idx_t;
  typedef logic [ADDR_BITS-1:0]            addr_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/fb_block_reader_pingpong_buffer.sv
// Two block buffers: one fills from DRAM while the other unpacks into a pixel stream.
// Latency: a filled block presents its first pixel the cycle after the fill.
// Backpressure: pix_vld/pix_rdy; the drain index holds while pix_rdy is low.
module fb_pingpong_buffer
  import fb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   fill_vld,
  input  block_t fill_dat,
  input  logic   pix_rdy,
  output logic   fill_full,
  output logic   pix_vld,
  output pixel_t pix_dat,
  output idx_t   drain_idx
);

  block_t     buf_q [2];
  block_t     buf_d [2];
  logic [1:0] full_q, full_d;
  logic       fill_ptr_q, fill_ptr_d;
  logic       drain_ptr_q, drain_ptr_d;
  idx_t       drain_idx_q, drain_idx_d;
  logic       pix_fire;

  assign fill_full = full_q[fill_ptr_q];
  assign pix_vld   = full_q[drain_ptr_q];
  assign pix_dat   = buf_q[drain_ptr_q][drain_idx_q];
  assign drain_idx = drain_idx_q;
  assign pix_fire  = pix_vld & pix_rdy;

  // Next state: drain frees its buffer, fill claims the other one; flush overrides both.
  always_comb begin
    buf_d       = buf_q;
    full_d      = full_q;
    fill_ptr_d  = fill_ptr_q;
    drain_ptr_d = drain_ptr_q;
    drain_idx_d = drain_idx_q;
    if (pix_fire) begin
      if (drain_idx_q == idx_t'(PPB - 1)) begin
        full_d[drain_ptr_q] = 1'b0;
        drain_idx_d         = '0;
        drain_ptr_d         = ~drain_ptr_q;
      end else begin
        drain_idx_d = drain_idx_q + idx_t'(1);
      end
    end
    // The fill buffer is always empty when a fill arrives, so it never collides with the drain side.
    if (fill_vld) begin
      buf_d[fill_ptr_q]  = fill_dat;
      full_d[fill_ptr_q] = 1'b1;
      fill_ptr_d         = ~fill_ptr_q;
    end
    if (flush) begin
      full_d      = '0;
      fill_ptr_d  = 1'b0;
      drain_ptr_d = 1'b0;
      drain_idx_d = '0;
    end
  end

  // Control state: flags, pointers and index, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= '0;
      fill_ptr_q  <= 1'b0;
      drain_ptr_q <= 1'b0;
      drain_idx_q <= '0;
    end else begin
      full_q      <= full_d;
      fill_ptr_q  <= fill_ptr_d;
      drain_ptr_q <= drain_ptr_d;
      drain_idx_q <= drain_idx_d;
    end
  end

  // Block storage needs no reset; the full flags gate every read.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: rtl/fb_block_reader.sv
// Fetches frame blocks from DRAM in order and streams their pixels to scan-out (optional stats: FB_READER_STATS_EN).
// Latency: request 1 cycle after reset release / buffer free; first pixel 1 cycle after read_response.
// Backpressure: pix_valid/pix_ready; fetching stalls while both block buffers are full.
module fb_block_reader
  import fb_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_PIXELS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  read_ready,
  output logic                  read_request,
  output logic [ADDR_BITS-1:0]  read_address,
  input  logic                  read_response,
  input  logic [BLOCK_BITS-1:0] read_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [PIXEL_BITS-1:0] pix_data,
  output logic                  pix_sof
`ifdef FB_READER_STATS_EN
  ,
  output logic [15:0]           underflow_count
`endif
);

  localparam logic [ADDR_BITS:0] FRAME_END = (ADDR_BITS + 1)'(FRAME_LEN);
  localparam logic [ADDR_BITS:0] PPB_STEP  = (ADDR_BITS + 1)'(PPB);

  fetch_state_t state_q, state_d;
  logic         read_request_q, read_request_d;
  addr_t        read_address_q, read_address_d;
  addr_t        fetch_addr_q, fetch_addr_d;
  logic         sof_q, sof_d;
  logic [ADDR_BITS:0] addr_sum;
  addr_t        fetch_next;
  logic         fill_vld;
  logic         fill_full;
  idx_t         drain_idx;

  assign read_request = read_request_q;
  assign read_address = read_address_q;
  assign addr_sum     = {1'b0, fetch_addr_q} + PPB_STEP;
  assign fetch_next   = (addr_sum >= FRAME_END) ? '0 : addr_sum[ADDR_BITS-1:0];
  // A response that races a frame_start belongs to the old frame and is discarded.
  assign fill_vld     = read_response & (state_q == WAIT) & ~frame_start;
  assign pix_sof      = pix_valid & (drain_idx == '0) & sof_q;

  fb_pingpong_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (frame_start),
    .fill_vld  (fill_vld),
    .fill_dat  (block_t'(read_data)),
    .pix_rdy   (pix_ready),
    .fill_full (fill_full),
    .pix_vld   (pix_valid),
    .pix_dat   (pix_data),
    .drain_idx (drain_idx)
  );

  // Fetch FSM next state: one outstanding request, address walk with frame wrap, sof flag.
  always_comb begin
    state_d        = state_q;
    read_request_d = 1'b0;
    read_address_d = read_address_q;
    fetch_addr_d   = fetch_addr_q;
    sof_d          = sof_q;
    case (state_q)
      IDLE: begin
        // Hold off issuing in a frame_start cycle so the request carries the restarted address.
        if (!frame_start && !fill_full && read_ready) begin
          state_d        = WAIT;
          read_request_d = 1'b1;
          read_address_d = fetch_addr_q;
        end
      end
      WAIT: begin
        if (read_response) begin
          state_d = IDLE;
          if (!frame_start) fetch_addr_d = fetch_next;
        end else if (frame_start) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (read_response) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pix_valid && pix_ready) sof_d = 1'b0;
    if (frame_start) begin
      fetch_addr_d = '0;
      sof_d        = 1'b1;
    end
  end

  // Fetch FSM and registered request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      read_request_q <= 1'b0;
      read_address_q <= '0;
      fetch_addr_q   <= '0;
      sof_q          <= 1'b1;
    end else begin
      state_q        <= state_d;
      read_request_q <= read_request_d;
      read_address_q <= read_address_d;
      fetch_addr_q   <= fetch_addr_d;
      sof_q          <= sof_d;
    end
  end

`ifdef FB_READER_STATS_EN
  logic [15:0] underflow_q, underflow_d;

  assign underflow_count = underflow_q;

  // Count cycles where scan-out wanted a pixel and none was available; saturates.
  always_comb begin
    underflow_d = underflow_q;
    if (pix_ready && !pix_valid && underflow_q != 16'hFFFF) underflow_d = underflow_q + 16'd1;
    if (frame_start) underflow_d = '0;
  end

  // Underflow counter register.
  always_ff @(posedge clk) begin
    if (rst) underflow_q <= '0;
    else     underflow_q <= underflow_d;
  end
`endif

endmodule

// File: tb/tb_fb_block_reader.sv
// Directed bench for fb_block_reader using a reduced 1024-pixel frame so the wrap is reachable.
// Latency: n/a.
// Backpressure: bench drives pix_ready patterns and a fixed-delay DRAM responder.
module tb_fb_block_reader;
  import fb_pkg::*;

  localparam int FRAME = 1024;

  logic                  clk;
  logic                  rst;
  logic                  frame_start;
  logic                  read_ready;
  logic                  read_request;
  logic [ADDR_BITS-1:0]  read_address;
  logic                  read_response;
  logic [BLOCK_BITS-1:0] read_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic [PIXEL_BITS-1:0] pix_data;
  logic                  pix_sof;
`ifdef FB_READER_STATS_EN
  logic [15:0]           underflow_count;
`endif

  fb_block_reader #(.FRAME_LEN(FRAME)) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .read_ready    (read_ready),
    .read_request  (read_request),
    .read_address  (read_address),
    .read_response (read_response),
    .read_data     (read_data),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_data      (pix_data),
    .pix_sof       (pix_sof)
`ifdef FB_READER_STATS_EN
    ,
    .underflow_count (underflow_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  int exp_pix;
  int exp_addr;
  int pend_addr;
  int dly;
  int gaps;
  int drained;
  bit pend;
  bit saw_req;
  bit started;
  bit sof_flag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Block whose pixel i carries the low bits of its global pixel index.
  function automatic block_t mk_blk(input int base);
    block_t b;
    for (int i = 0; i < PPB; i++) b[i] = 16'(base + i);
    return b;
  endfunction

  // One clock: watch requests, answer them two cycles later, drive pix_ready, check the stream.
  task automatic cycle(input bit rdy);
    @(posedge clk);
    #1;
    saw_req = 1'b0;
    if (read_request === 1'b1) begin
      saw_req = 1'b1;
      chk("one_outstanding", 32'(pend), 32'd0);
      chk("req_addr", 32'(read_address), 32'(exp_addr));
      exp_addr  = (exp_addr + PPB) % FRAME;
      pend      = 1'b1;
      dly       = 2;
      pend_addr = int'(read_address);
    end
    read_response = 1'b0;
    if (pend) begin
      if (dly == 0) begin
        read_response = 1'b1;
        read_data     = mk_blk(pend_addr);
        pend          = 1'b0;
      end else begin
        dly--;
      end
    end
    pix_ready = rdy;
    #1;
    if (pix_valid === 1'b1) begin
      started = 1'b1;
      chk("pix_data", 32'(pix_data), 32'(16'(exp_pix)));
      chk("pix_sof", 32'(pix_sof), 32'(sof_flag));
      if (rdy) begin
        exp_pix  = (exp_pix + 1) % FRAME;
        sof_flag = 1'b0;
        drained++;
      end
    end else if (started && rdy) begin
      gaps++;
    end
  endtask

  initial begin
    rst           = 1'b1;
    frame_start   = 1'b0;
    read_ready    = 1'b0;
    read_response = 1'b0;
    read_data     = '0;
    pix_ready     = 1'b0;
    exp_pix = 0; exp_addr = 0; pend_addr = 0; dly = 0;
    gaps = 0; drained = 0; pend = 0; saw_req = 0; started = 0; sof_flag = 1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read_request", 32'(read_request), 32'd0);
    chk("rst_read_address", 32'(read_address), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_sof", 32'(pix_sof), 32'd0);
`ifdef FB_READER_STATS_EN
    chk("rst_underflow", 32'(underflow_count), 32'd0);
`endif

    // First request one cycle after reset release
    rst        = 1'b0;
    read_ready = 1'b1;
    cycle(1'b1);
    chk("first_req_latency", 32'(saw_req), 32'd1);

    // Stream up to pixel 37, stall 10 cycles (pix_data must hold), then resume
    for (int n = 0; n < 400 && exp_pix != 37; n++) cycle(1'b1);
    chk("reached_pixel_37", 32'(exp_pix), 32'd37);
    repeat (10) cycle(1'b0);

    // Run past the frame wrap: addresses 0,256,512,768,0,... with no refill gaps, no second sof
    for (int n = 0; n < 2000 && drained < FRAME + 300; n++) cycle(1'b1);
    chk("drain_progress", 32'(drained >= FRAME + 300), 32'd1);
    chk("no_gap", 32'(gaps), 32'd0);

    // frame_start while a request is outstanding: response dropped, refetch from 0
    for (int n = 0; n < 600 && !saw_req; n++) cycle(1'b1);
    chk("wait_req_seen", 32'(saw_req), 32'd1);
    pend        = 1'b0;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    #1;
    chk("fs_pix_valid", 32'(pix_valid), 32'd0);
    chk("fs_read_request", 32'(read_request), 32'd0);
    read_response = 1'b1;
    read_data     = mk_blk(512);
    @(posedge clk);
    #1;
    read_response = 1'b0;
    #1;
    chk("drop_pix_valid", 32'(pix_valid), 32'd0);
    chk("drop_read_request", 32'(read_request), 32'd0);
    @(posedge clk);
    #1;
    chk("restart_req", 32'(read_request), 32'd1);
    chk("restart_addr", 32'(read_address), 32'd0);
    exp_addr  = PPB;
    pend      = 1'b1;
    dly       = 1;
    pend_addr = 0;
    exp_pix   = 0;
    sof_flag  = 1'b1;
    started   = 1'b0;
    drained   = 0;
    repeat (300) cycle(1'b1);
    chk("restart_progress", 32'(drained > 200), 32'd1);

`ifdef FB_READER_STATS_EN
    // Underflow counter: 5 starved cycles, cleared by frame_start
    read_ready    = 1'b0;
    read_response = 1'b0;
    pix_ready     = 1'b0;
    frame_start   = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    chk("uf_cleared", 32'(underflow_count), 32'd0);
    pix_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("uf_five", 32'(underflow_count), 32'd5);
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    chk("uf_fs_clear", 32'(underflow_count), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
